// File: rtl/pellet_map.sv
// rtl/pellet_map.sv - maze pellet map: image reload sweep, per-pixel sprite lookup, eat port
//
// Purpose:
//   Holds the live pellet map for a COLS x ROWS tile maze (2-bit code per cell:
//   00 empty, 01 dot, 10 power pellet, 11 treated as empty). After reset or a
//   restore request the map is refilled from a read-only image, one cell per
//   cycle, while the non-empty cells are counted. Once live, the block answers
//   "is this pixel inside a pellet sprite" one cycle after DrawX/DrawY, and lets
//   the player consume the pellet under its centre.
//
// Ports:
//   Clk                             system clock
//   Reset                           synchronous, active-low
//   restore_req                     one-cycle pulse: refill the map from the image
//   DrawX, DrawY                    current pixel coordinates
//   Ball_X_Pos_out, Ball_Y_Pos_out  player centre coordinates
//   eat_req                         consume the pellet in the player's cell
//   is_dot, is_power                pixel lies inside a dot / power sprite square
//   tile_has_pellet                 pixel's cell holds any pellet
//   eaten_dot, eaten_power          one-cycle pulse after a pellet is consumed
//   dots_left                       number of non-empty cells
//   level_clear                     ready and no pellets remain
//   ready                           map is loaded and live
//
// The image contents are carried in IMAGE (generated from the INIT_FILE artwork
// by the asset flow); an empty INIT_FILE name selects a blank maze.

module pellet_map #(
  parameter int    COLS       = 20,
  parameter int    ROWS       = 11,
  parameter int    TILE_SHIFT = 5,
  parameter int    DOT_SIZE   = 5,
  parameter int    PWR_SIZE   = 12,
  parameter string INIT_FILE  = "sprite_bytes/pellets.txt",
  // Cell 0 sits in the least significant two bits.
  parameter logic [2*COLS*ROWS-1:0] IMAGE =
    {{(COLS*ROWS-22){2'b01}}, 2'b10, {20{2'b01}}, 2'b00}
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             restore_req,
  input  logic [9:0]                       DrawX,
  input  logic [9:0]                       DrawY,
  input  logic [9:0]                       Ball_X_Pos_out,
  input  logic [9:0]                       Ball_Y_Pos_out,
  input  logic                             eat_req,
  output logic                             is_dot,
  output logic                             is_power,
  output logic                             tile_has_pellet,
  output logic                             eaten_dot,
  output logic                             eaten_power,
  output logic [$clog2(COLS*ROWS+1)-1:0]   dots_left,
  output logic                             level_clear,
  output logic                             ready
);

  localparam int CELLS = COLS * ROWS;
  localparam int IDXW  = $clog2(CELLS);
  localparam int DLW   = $clog2(CELLS + 1);
  // Signed width wide enough for an intra-tile offset around the tile centre.
  localparam int DW    = TILE_SHIFT + 2;

  localparam logic [IDXW-1:0]      LAST_IDX  = IDXW'(CELLS - 1);
  localparam logic signed [DW-1:0] HALF_TILE = DW'(1 << (TILE_SHIFT - 1));
  localparam logic signed [DW-1:0] DOT_HI    = DW'(DOT_SIZE);
  localparam logic signed [DW-1:0] PWR_LO    = DW'(-(PWR_SIZE / 2));
  localparam logic signed [DW-1:0] PWR_HI    = DW'(PWR_SIZE / 2);

  localparam logic [1:0] CODE_EMPTY = 2'b00;
  localparam logic [1:0] CODE_DOT   = 2'b01;
  localparam logic [1:0] CODE_PWR   = 2'b10;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2*CELLS-1:0] IMAGE_BITS = (INIT_FILE == "") ? '0 : IMAGE;

  // Returns {in_range, cell_index}; out-of-range coordinates give all zeros.
  function automatic logic [IDXW:0] cell_lookup(input logic [9:0] x, input logic [9:0] y);
    int tx;
    int ty;
    tx = int'(x >> TILE_SHIFT);
    ty = int'(y >> TILE_SHIFT);
    if (tx < COLS && ty < ROWS) begin
      cell_lookup = {1'b1, IDXW'(ty * COLS + tx)};
    end else begin
      cell_lookup = '0;
    end
  endfunction

  // Offset of a coordinate from the centre of its tile, signed.
  function automatic logic signed [DW-1:0] tile_offset(input logic [9:0] p);
    tile_offset = $signed({2'b00, p[TILE_SHIFT-1:0]}) - HALF_TILE;
  endfunction

  function automatic logic is_pellet(input logic [1:0] code);
    is_pellet = (code == CODE_DOT) || (code == CODE_PWR);
  endfunction

  logic [0:0]      state;
  logic [IDXW-1:0] load_idx;
  logic [DLW-1:0]  dots_q;
  logic [1:0]      map_ram [CELLS];

  logic            px_valid;
  logic [IDXW-1:0] px_idx;
  logic            eat_valid;
  logic [IDXW-1:0] eat_idx;
  logic [1:0]      px_code;
  logic [1:0]      eat_code;
  logic [1:0]      img_code;
  logic signed [DW-1:0] px_dx;
  logic signed [DW-1:0] px_dy;
  logic            px_dot;
  logic            px_pwr;
  logic            px_any;
  logic            eat_hit;

  logic            ram_we;
  logic [IDXW-1:0] ram_waddr;
  logic [1:0]      ram_wdata;

  assign {px_valid, px_idx}   = cell_lookup(DrawX, DrawY);
  assign {eat_valid, eat_idx} = cell_lookup(Ball_X_Pos_out, Ball_Y_Pos_out);

  // Both lookups see the RAM before this cycle's write, so a pixel read and
  // an eat of the same cell in one cycle report the pre-clear code.
  assign px_code  = px_valid  ? map_ram[px_idx]  : CODE_EMPTY;
  assign eat_code = eat_valid ? map_ram[eat_idx] : CODE_EMPTY;
  assign img_code = IMAGE_BITS[{load_idx, 1'b0} +: 2];

  assign px_dx = tile_offset(DrawX);
  assign px_dy = tile_offset(DrawY);

  // Dot square starts at the tile centre; power square is centred on it.
  assign px_dot = (px_code == CODE_DOT) &&
                  !px_dx[DW-1] && (px_dx < DOT_HI) &&
                  !px_dy[DW-1] && (px_dy < DOT_HI);
  assign px_pwr = (px_code == CODE_PWR) &&
                  (px_dx >= PWR_LO) && (px_dx < PWR_HI) &&
                  (px_dy >= PWR_LO) && (px_dy < PWR_HI);
  assign px_any = is_pellet(px_code);

  // Consuming an already-empty cell is a no-op, which also makes a held
  // eat_req take the pellet exactly once.
  assign eat_hit = (state == ST_RUN) && eat_req && eat_valid && is_pellet(eat_code);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = load_idx;
    ram_wdata = img_code;
    if (Reset && !restore_req) begin
      if (state == ST_LOAD) begin
        ram_we = 1'b1;
      end else if (eat_hit) begin
        ram_we    = 1'b1;
        ram_waddr = eat_idx;
        ram_wdata = CODE_EMPTY;
      end
    end
  end

  // Map storage has no reset; every cell is rewritten by the load sweep.
  always_ff @(posedge Clk) begin
    if (ram_we) begin
      map_ram[ram_waddr] <= ram_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset || restore_req) begin
      state           <= ST_LOAD;
      load_idx        <= '0;
      dots_q          <= '0;
      is_dot          <= 1'b0;
      is_power        <= 1'b0;
      tile_has_pellet <= 1'b0;
      eaten_dot       <= 1'b0;
      eaten_power     <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          is_dot          <= 1'b0;
          is_power        <= 1'b0;
          tile_has_pellet <= 1'b0;
          eaten_dot       <= 1'b0;
          eaten_power     <= 1'b0;
          if (is_pellet(img_code)) begin
            dots_q <= dots_q + 1'b1;
          end
          if (load_idx == LAST_IDX) begin
            state <= ST_RUN;
          end else begin
            load_idx <= load_idx + 1'b1;
          end
        end
        default: begin
          is_dot          <= px_dot;
          is_power        <= px_pwr;
          tile_has_pellet <= px_any;
          eaten_dot       <= eat_hit && (eat_code == CODE_DOT);
          eaten_power     <= eat_hit && (eat_code == CODE_PWR);
          if (eat_hit && (dots_q != '0)) begin
            dots_q <= dots_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign ready       = (state == ST_RUN);
  assign dots_left   = dots_q;
  assign level_clear = ready && (dots_q == '0);

endmodule

// File: tb/tb_pellet_map.sv
// tb/tb_pellet_map.sv - self-checking bench for pellet_map with a cell-array reference model

module tb_pellet_map;

  localparam int COLS  = 20;
  localparam int ROWS  = 11;
  localparam int CELLS = COLS * ROWS;
  localparam int TILE  = 32;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       restore_req;
  logic [9:0] DrawX, DrawY, Ball_X_Pos_out, Ball_Y_Pos_out;
  logic       eat_req;
  logic       is_dot, is_power, tile_has_pellet, eaten_dot, eaten_power;
  logic [7:0] dots_left;
  logic       level_clear, ready;

  always #5 Clk = ~Clk;

  pellet_map dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .restore_req    (restore_req),
    .DrawX          (DrawX),
    .DrawY          (DrawY),
    .Ball_X_Pos_out (Ball_X_Pos_out),
    .Ball_Y_Pos_out (Ball_Y_Pos_out),
    .eat_req        (eat_req),
    .is_dot         (is_dot),
    .is_power       (is_power),
    .tile_has_pellet(tile_has_pellet),
    .eaten_dot      (eaten_dot),
    .eaten_power    (eaten_power),
    .dots_left      (dots_left),
    .level_clear    (level_clear),
    .ready          (ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int model_map[CELLS];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Level image: cell 0 empty, cell 21 power, every other cell a dot.
  task automatic model_fill();
    for (int c = 0; c < CELLS; c++) model_map[c] = 1;
    model_map[0]  = 0;
    model_map[21] = 2;
  endtask

  function automatic int model_count();
    int n = 0;
    for (int c = 0; c < CELLS; c++) if (model_map[c] == 1 || model_map[c] == 2) n++;
    return n;
  endfunction

  function automatic int cell_of(input int x, input int y);
    if (x / TILE >= COLS || y / TILE >= ROWS) return -1;
    return (y / TILE) * COLS + (x / TILE);
  endfunction

  function automatic int code_at(input int x, input int y);
    int c = cell_of(x, y);
    if (c < 0) return 0;
    return (model_map[c] == 1 || model_map[c] == 2) ? model_map[c] : 0;
  endfunction

  task automatic expect_pixel(input int x, input int y, output int dot, output int pwr, output int any);
    int code = code_at(x, y);
    int dx = (x % TILE) - TILE / 2;
    int dy = (y % TILE) - TILE / 2;
    dot = (code == 1 && dx >= 0 && dx < 5 && dy >= 0 && dy < 5) ? 1 : 0;
    pwr = (code == 2 && dx >= -6 && dx < 6 && dy >= -6 && dy < 6) ? 1 : 0;
    any = (code != 0) ? 1 : 0;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_ready(output int cycles, output int noisy);
    cycles = 0;
    noisy  = 0;
    while (!ready && cycles < 1000) begin
      step();
      cycles++;
      if (!ready && (is_dot || is_power || tile_has_pellet || eaten_dot || eaten_power || level_clear))
        noisy = 1;
    end
  endtask

  task automatic set_draw(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  task automatic set_ball(input int x, input int y);
    Ball_X_Pos_out = 10'(x);
    Ball_Y_Pos_out = 10'(y);
  endtask

  int cyc, noisy, pulses;
  int ed, ep, ex, ey, bx, by, bcode, bcell, e;
  int dot, pwr, any;

  initial begin
    Reset = 1'b0;
    restore_req = 1'b0;
    eat_req = 1'b1;          // must be ignored throughout the load sweep
    set_draw(48, 48);
    set_ball(48, 48);
    step();
    step();
    check_eq("rst_ready", ready, 0);
    check_eq("rst_dots", dots_left, 0);
    check_eq("rst_clear", level_clear, 0);
    check_eq("rst_pixel", is_dot | is_power | tile_has_pellet, 0);
    check_eq("rst_pulse", eaten_dot | eaten_power, 0);

    model_fill();
    Reset = 1'b1;
    wait_ready(cyc, noisy);
    eat_req = 1'b0;
    check_eq("load_latency", cyc, 220);
    check_eq("load_quiet", noisy, 0);
    check_eq("load_dots", dots_left, 219);
    check_eq("load_clear", level_clear, 0);

    // Sprite geometry around known cells.
    set_draw(48, 48); step();
    check_eq("pwr_centre_is_power", is_power, 1);
    check_eq("pwr_centre_is_dot", is_dot, 0);
    set_draw(80, 16); step();
    check_eq("dot_centre", is_dot, 1);
    set_draw(70, 16); step();
    check_eq("dot_off_square", is_dot, 0);
    check_eq("dot_off_has", tile_has_pellet, 1);

    // Eat the power pellet, then try again on the now-empty cell.
    set_ball(48, 48); eat_req = 1'b1; step(); eat_req = 1'b0;
    check_eq("eat_pwr_pulse", eaten_power, 1);
    check_eq("eat_pwr_nodot", eaten_dot, 0);
    check_eq("eat_pwr_dots", dots_left, 218);
    model_map[21] = 0;
    step();
    check_eq("eat_pwr_single", eaten_power, 0);
    eat_req = 1'b1; step(); eat_req = 1'b0;
    check_eq("eat_again_pulse", eaten_power, 0);
    check_eq("eat_again_dots", dots_left, 218);

    // Same-cycle read and eat of cell 2 returns the pre-clear code.
    set_ball(80, 16); set_draw(80, 16); eat_req = 1'b1; step(); eat_req = 1'b0;
    check_eq("rbw_is_dot", is_dot, 1);
    check_eq("rbw_eaten", eaten_dot, 1);
    model_map[2] = 0;
    step();
    check_eq("rbw_after", is_dot, 0);
    set_draw(700, 16); step();
    check_eq("oor_pixel", is_dot | is_power | tile_has_pellet, 0);

    // Held eat_req consumes once.
    set_ball(112, 16); eat_req = 1'b1; pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += eaten_dot;
    end
    eat_req = 1'b0;
    model_map[3] = 0;
    check_eq("held_eat_pulses", pulses, 1);
    check_eq("held_eat_dots", dots_left, model_count());

    // Randomized pixel reads and eats against the cell-array model.
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ex = $urandom_range(0, 21) * TILE + TILE / 2 + $urandom_range(0, 20) - 10;
        ey = $urandom_range(0, 12) * TILE + TILE / 2 + $urandom_range(0, 20) - 10;
      end else begin
        ex = $urandom_range(0, 1023);
        ey = $urandom_range(0, 1023);
      end
      bx = $urandom_range(0, 21) * TILE + TILE / 2;
      by = $urandom_range(0, 12) * TILE + TILE / 2;
      e  = ($urandom_range(0, 2) == 0) ? 1 : 0;
      expect_pixel(ex, ey, dot, pwr, any);
      bcode = code_at(bx, by);
      bcell = cell_of(bx, by);
      ed = (e == 1 && bcode == 1) ? 1 : 0;
      ep = (e == 1 && bcode == 2) ? 1 : 0;
      if (ed == 1 || ep == 1) model_map[bcell] = 0;
      set_draw(ex, ey); set_ball(bx, by); eat_req = e[0];
      step();
      eat_req = 1'b0;
      check_eq("rnd_is_dot", is_dot, dot);
      check_eq("rnd_is_power", is_power, pwr);
      check_eq("rnd_has", tile_has_pellet, any);
      check_eq("rnd_eaten_dot", eaten_dot, ed);
      check_eq("rnd_eaten_power", eaten_power, ep);
      check_eq("rnd_dots", dots_left, model_count());
      check_eq("rnd_clear", level_clear, (model_count() == 0) ? 1 : 0);
    end

    // Clear the rest of the board.
    for (int c = 0; c < CELLS; c++) begin
      if (model_map[c] != 0) begin
        ed = (model_map[c] == 1) ? 1 : 0;
        model_map[c] = 0;
        set_ball((c % COLS) * TILE + 5, (c / COLS) * TILE + 27);
        eat_req = 1'b1; step(); eat_req = 1'b0;
        check_eq("clear_pulse", eaten_dot + 2 * eaten_power, ed ? 1 : 2);
      end
    end
    check_eq("clear_dots", dots_left, 0);
    check_eq("clear_level", level_clear, 1);
    set_ball(48, 48); eat_req = 1'b1; step(); eat_req = 1'b0;
    check_eq("underflow_dots", dots_left, 0);
    check_eq("underflow_pulse", eaten_dot | eaten_power, 0);

    // Level restart.
    restore_req = 1'b1; step(); restore_req = 1'b0;
    check_eq("restore_ready", ready, 0);
    check_eq("restore_clear", level_clear, 0);
    wait_ready(cyc, noisy);
    check_eq("restore_latency", cyc, 220);
    check_eq("restore_quiet", noisy, 0);
    check_eq("restore_dots", dots_left, 219);
    check_eq("restore_level", level_clear, 0);

    // Restore wins over a simultaneous eat.
    set_ball(48, 48); restore_req = 1'b1; eat_req = 1'b1; step();
    restore_req = 1'b0; eat_req = 1'b0;
    check_eq("prio_pulse", eaten_power, 0);
    check_eq("prio_ready", ready, 0);
    check_eq("prio_dots", dots_left, 0);
    // Restore mid-sweep restarts from index 0.
    for (int i = 0; i < 50; i++) step();
    restore_req = 1'b1; step(); restore_req = 1'b0;
    wait_ready(cyc, noisy);
    check_eq("restart_latency", cyc, 220);
    check_eq("restart_dots", dots_left, 219);

    // Reset pulse in the middle of a sweep.
    restore_req = 1'b1; step(); restore_req = 1'b0;
    for (int i = 0; i < 100; i++) step();
    Reset = 1'b0; step(); Reset = 1'b1;
    check_eq("midrst_ready", ready, 0);
    check_eq("midrst_dots", dots_left, 0);
    wait_ready(cyc, noisy);
    check_eq("midrst_latency", cyc, 220);
    check_eq("midrst_final_dots", dots_left, 219);
    model_fill();
    set_draw(48, 48); step();
    check_eq("midrst_pwr_back", is_power, 1);
    set_draw(80, 16); step();
    check_eq("midrst_dot_back", is_dot, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
